// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: character indices,
// the blank pattern and the 32-entry active-low segment table {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int CODE_W     = 6;
  localparam int SEG_W      = 7;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [SEG_W-1:0]  seg_t;
  typedef logic [4:0]        char_idx_t;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam char_idx_t CHAR_0     = 5'd0;
  localparam char_idx_t CHAR_9     = 5'd9;
  localparam char_idx_t CHAR_A     = 5'd10;
  localparam char_idx_t CHAR_F     = 5'd15;
  localparam char_idx_t CHAR_DASH  = 5'd16;
  localparam char_idx_t CHAR_H     = 5'd17;
  localparam char_idx_t CHAR_L     = 5'd18;
  localparam char_idx_t CHAR_P     = 5'd19;
  localparam char_idx_t CHAR_U     = 5'd20;
  localparam char_idx_t CHAR_R     = 5'd21;
  localparam char_idx_t CHAR_N     = 5'd22;
  localparam char_idx_t CHAR_O     = 5'd23;
  localparam char_idx_t CHAR_Y     = 5'd24;
  localparam char_idx_t CHAR_T     = 5'd25;
  localparam char_idx_t CHAR_UNDER = 5'd26;

  // Indices 27..31 are unassigned and stay blank.
  localparam seg_t SEG_TABLE [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,  // 0-7
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,  // 8,9,A,b,C,d,E,F
    7'h3F, 7'h09, 7'h47, 7'h0C, 7'h41, 7'h2F, 7'h2B, 7'h23,  // -,H,L,P,U,r,n,o
    7'h11, 7'h07, 7'h77, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F   // y,t,_,blank
  };

  function automatic seg_t char_to_seg(input char_idx_t idx);
    return SEG_TABLE[idx];
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Bundle between the display manager and the scanner: eight character codes in,
// multiplexed segment/anode pins and the frame strobe out. DISPLAY_SCANNER_BLINK_EN adds blink.
interface display_scanner_if;
  import display_pkg::*;

  code_t       d1, d2, d3, d4, d5, d6, d7, d8;
  seg_t        seg;
  logic [7:0]  an;
  logic        frame_start;
`ifdef DISPLAY_SCANNER_BLINK_EN
  logic [7:0]  blink;
`endif

  modport master (
`ifdef DISPLAY_SCANNER_BLINK_EN
    output blink,
`endif
    output d1, d2, d3, d4, d5, d6, d7, d8,
    input  seg, an, frame_start
  );

  modport slave (
`ifdef DISPLAY_SCANNER_BLINK_EN
    input  blink,
`endif
    input  d1, d2, d3, d4, d5, d6, d7, d8,
    output seg, an, frame_start
  );

endinterface

// File: rtl/display_scanner_seg_decoder.sv
// Combinational character decoder: 6-bit code {index, enable} to active-low
// segments. Kept standalone so other display paths can reuse it.
module seg_decoder
  import display_pkg::*;
(
  input  code_t code,
  output seg_t  seg
);

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (code[0]) seg = char_to_seg(code[5:1]);
  end

endmodule

// File: rtl/display_scanner.sv
// Eight-digit time-multiplexed seven-segment scanner with per-frame snapshot of
// the character codes. Optional blinking is enabled by DISPLAY_SCANNER_BLINK_EN.
module display_scanner
  import display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000
`ifdef DISPLAY_SCANNER_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic clock,
  input  logic reset,
  display_scanner_if.slave bus
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             snap;
  phase_e           phase;

  code_t live   [NUM_DIGITS];
  code_t shadow [NUM_DIGITS];
  seg_t  dec_seg;

  logic [7:0] an_next, an_q;
  seg_t       seg_next, seg_q;
  logic       frame_start_q;

  assign live = '{bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6, bus.d7, bus.d8};

  // The snapshot edge is the first edge of slot 0, so a frame always shows one
  // coherent set of codes.
  assign snap  = (idx == 3'd0) && (cnt == '0);
  assign phase = (cnt < CNT_BLANK) ? PH_BLANK : PH_DRIVE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // NOTE: the shadow bank is reset on purpose (unlike a plain storage array) so
  // the display comes up blank instead of showing whatever powered up.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= live[i];
    end
  end

  seg_decoder u_seg_decoder (
    .code (shadow[idx]),
    .seg  (dec_seg)
  );

`ifdef DISPLAY_SCANNER_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);

  logic [FC_W-1:0] frame_cnt;
  logic            blink_on;
  logic [7:0]      blink_s;
  logic            hide;

  // frame_cnt counts snapshots within the current phase; the toggle lands on the
  // snapshot that opens frame BLINK_FRAMES+1 of that phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
      blink_s   <= 8'h00;
    end else if (snap) begin
      blink_s <= bus.blink;
      if (frame_cnt == FC_W'(BLINK_FRAMES)) begin
        blink_on  <= ~blink_on;
        frame_cnt <= FC_W'(1);
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign hide = !blink_on && blink_s[3'd7 - idx];
`endif

  always_comb begin
    an_next  = 8'hFF;
    seg_next = SEG_BLANK;
    if (phase == PH_DRIVE) begin
      an_next  = ~(8'h80 >> idx);
      seg_next = dec_seg;
`ifdef DISPLAY_SCANNER_BLINK_EN
      if (hide) seg_next = SEG_BLANK;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an_q          <= 8'hFF;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      an_q          <= an_next;
      seg_q         <= seg_next;
      frame_start_q <= snap;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner with DIGIT_CYCLES=8, BLANK_CYCLES=2: a frame-position
// model checked every cycle, plus directed literal checks. Blink part under DISPLAY_SCANNER_BLINK_EN.
module tb_display_scanner;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * DC;
`ifdef DISPLAY_SCANNER_BLINK_EN
  localparam int BF    = 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  display_scanner_if bus ();

  display_scanner #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
`ifdef DISPLAY_SCANNER_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Active-high glyphs as drawn on a display, inverted for the active-low pins.
  function automatic logic [6:0] glyph(input logic [5:0] code);
    logic [6:0] on;
    if (!code[0]) return 7'h7F;
    case (code[5:1])
      0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
      4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
      8: on = 7'h7F;  9: on = 7'h6F; 10: on = 7'h77; 11: on = 7'h7C;
     12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; 15: on = 7'h71;
     16: on = 7'h40; 17: on = 7'h76; 18: on = 7'h38; 19: on = 7'h73;
     20: on = 7'h3E; 21: on = 7'h50; 22: on = 7'h54; 23: on = 7'h5C;
     24: on = 7'h6E; 25: on = 7'h78; 26: on = 7'h08;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  // Model: e counts edges since reset release; edge 1 is the first snapshot.
  int         e = 0;
  bit         started = 0;
  logic [5:0] snap_m [8];
  logic [7:0] blink_m = 8'h00;

  always @(posedge clock) begin
    started = 1;
    if (reset) begin
      e = 0;
      for (int i = 0; i < 8; i++) snap_m[i] = '0;
      blink_m = 8'h00;
    end else begin
      e++;
      if ((e - 1) % FRAME == 0) begin
        snap_m[0] = bus.d1; snap_m[1] = bus.d2; snap_m[2] = bus.d3; snap_m[3] = bus.d4;
        snap_m[4] = bus.d5; snap_m[5] = bus.d6; snap_m[6] = bus.d7; snap_m[7] = bus.d8;
`ifdef DISPLAY_SCANNER_BLINK_EN
        blink_m = bus.blink;
`endif
      end
    end
  end

  int gap_run = 0;

  always @(negedge clock) begin
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fs;
    int f, k, off;
    if (started) begin
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_fs = 1'b0;
      if (e > 0) begin
        f   = (e - 1) % FRAME;
        k   = f / DC;
        off = f % DC;
        exp_fs = (f == 0);
        if (off >= BC) begin
          exp_an  = ~(8'h80 >> k);
          exp_seg = glyph(snap_m[k]);
`ifdef DISPLAY_SCANNER_BLINK_EN
          if (((((e - 1) / FRAME) / BF) % 2 == 1) && blink_m[7 - k]) exp_seg = 7'h7F;
`endif
        end
      end
      check("model_an", bus.an, exp_an);
      check("model_seg", bus.seg, exp_seg);
      check("model_frame_start", bus.frame_start, exp_fs);
      check("an_onehot", ($countones(~bus.an) <= 1), 1);
      if (e >= 1) begin
        if (bus.an == 8'hFF) gap_run++;
        else begin
          if (gap_run != 0) check("blank_gap_len", gap_run, BC);
          gap_run = 0;
        end
      end else gap_run = 0;
    end
  end

  task automatic wait_fs();
    int n = 0;
    do begin @(negedge clock); n++; end while (!bus.frame_start && n < 3 * FRAME);
    check("wait_frame_start", bus.frame_start, 1);
  endtask

  task automatic set_all(input logic [5:0] c);
    bus.d1 = c; bus.d2 = c; bus.d3 = c; bus.d4 = c;
    bus.d5 = c; bus.d6 = c; bus.d7 = c; bus.d8 = c;
  endtask

  initial begin
    int n;
    set_all(6'b000000);
`ifdef DISPLAY_SCANNER_BLINK_EN
    bus.blink = 8'h00;
`endif
    // Reset held 3 cycles.
    repeat (3) @(negedge clock);
    check("reset_an", bus.an, 8'hFF);
    check("reset_seg", bus.seg, 7'h7F);
    check("reset_fs", bus.frame_start, 0);

    // Single digit '1' on d1.
    bus.d1 = 6'b000011;
    reset = 1'b0;
    @(negedge clock);
    check("first_snapshot_fs", bus.frame_start, 1);
    check("first_snapshot_an", bus.an, 8'hFF);
    repeat (2) @(negedge clock);
    check("d1_cycle3_an", bus.an, 8'h7F);
    check("d1_cycle3_seg", bus.seg, 7'h79);
    repeat (5) @(negedge clock);
    check("d1_cycle8_an", bus.an, 8'h7F);
    check("d1_cycle8_seg", bus.seg, 7'h79);
    @(negedge clock);
    check("slot1_blank_an", bus.an, 8'hFF);
    repeat (2) @(negedge clock);
    check("slot1_an", bus.an, 8'hBF);
    check("slot1_seg", bus.seg, 7'h7F);

    // All-dash frame; mid-frame change waits for the next snapshot.
    set_all(6'b100001);
    wait_fs();
    n = 0;
    do begin
      @(negedge clock); n++;
      if (n == 2) begin
        check("dash_an", bus.an, 8'h7F);
        check("dash_seg", bus.seg, 7'h3F);
      end
    end while (!bus.frame_start && n < 3 * FRAME);
    check("frame_period", n, FRAME);

    // No tearing: d3 changes from '8' to '0' during slot 2.
    bus.d3 = 6'b010001;
    wait_fs();
    repeat (17) @(negedge clock);
    bus.d3 = 6'b000001;
    repeat (3) @(negedge clock);
    check("notear_an", bus.an, 8'hDF);
    check("notear_seg", bus.seg, 7'h00);
    wait_fs();
    repeat (18) @(negedge clock);
    check("newframe_an", bus.an, 8'hDF);
    check("newframe_seg", bus.seg, 7'h40);

    // Disabled digit keeps its slot but stays blank.
    bus.d2 = 6'b000010;
    wait_fs();
    repeat (10) @(negedge clock);
    check("disabled_an", bus.an, 8'hBF);
    check("disabled_seg", bus.seg, 7'h7F);

    // Reset mid-drive.
    reset = 1'b1;
    @(negedge clock);
    check("midreset_an", bus.an, 8'hFF);
    check("midreset_seg", bus.seg, 7'h7F);
    check("midreset_fs", bus.frame_start, 0);
    reset = 1'b0;
    @(negedge clock);
    check("restart_fs", bus.frame_start, 1);
    repeat (FRAME + 5) @(negedge clock);

`ifdef DISPLAY_SCANNER_BLINK_EN
    set_all(6'b100001);
    bus.d1    = 6'b000011;
    bus.blink = 8'h80;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    repeat (2) @(negedge clock);
    check("blink_f1_an", bus.an, 8'h7F);
    check("blink_f1_seg", bus.seg, 7'h79);
    repeat (FRAME) @(negedge clock);
    check("blink_f2_seg", bus.seg, 7'h79);
    repeat (FRAME) @(negedge clock);
    check("blink_f3_an", bus.an, 8'h7F);
    check("blink_f3_seg", bus.seg, 7'h7F);
    repeat (DC) @(negedge clock);
    check("blink_f3_d2_seg", bus.seg, 7'h3F);
    repeat (FRAME - DC) @(negedge clock);
    check("blink_f4_seg", bus.seg, 7'h7F);
    repeat (FRAME) @(negedge clock);
    check("blink_f5_seg", bus.seg, 7'h79);
`endif

    repeat (4) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
